// File: rtl/fir_ram_pkg.sv
// Shared types and helpers for the RAM-based FIR front end.
package fir_ram_pkg;

  localparam int DEFAULT_EXTRA_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WAIT
  } pacer_state_t;

  // Cycles one FIR multiply-accumulate pass occupies, plus pipeline margin.
  function automatic int calc_slot_cycles(input int order, input int parallel, input int extra);
    return order / parallel + extra;
  endfunction

endpackage

// File: rtl/fir_ram_sample_fifo.sv
// Synchronous circular FIFO with one-bit-wide pointer extension for full/empty.
// Head data is visible combinationally on rd_data.
module fir_ram_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [LVL_WIDTH-1:0]  level
);

  localparam int ADDR_WIDTH = LVL_WIDTH - 1;
  localparam logic [LVL_WIDTH-1:0] PTR_ONE = LVL_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LVL_WIDTH-1:0]  wr_ptr;
  logic [LVL_WIDTH-1:0]  rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_ram_sample_pacer.sv
// Buffers bursty input samples and releases them to the RAM-based FIR as
// single-cycle strobes spaced at least one FIR pass apart.
module fir_ram_sample_pacer
  import fir_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FILTER_ORDER = 256,
  parameter int PARALLEL     = 4,
  parameter int EXTRA_CYCLES = DEFAULT_EXTRA_CYCLES,
  parameter int FIFO_DEPTH   = 16,
  parameter int SLOT_CYCLES  = calc_slot_cycles(FILTER_ORDER, PARALLEL, EXTRA_CYCLES),
  parameter int LVL_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_val_i,
  output logic                  ready_o,
  input  logic                  ovf_clr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_val_o,
  output logic [LVL_WIDTH-1:0]  level_o,
  output logic                  ovf_o
);

  localparam int CNT_WIDTH = $clog2(SLOT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(SLOT_CYCLES - 1);

  if (FILTER_ORDER % PARALLEL != 0) begin : g_chk_parallel
    $error("FILTER_ORDER must be a multiple of PARALLEL");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (SLOT_CYCLES != calc_slot_cycles(FILTER_ORDER, PARALLEL, EXTRA_CYCLES)) begin : g_chk_slot
    $error("SLOT_CYCLES is derived and must not be overridden");
  end

  pacer_state_t          state_q;
  pacer_state_t          state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  rd_en;
  logic                  wr_en;
  logic                  drop;

  fir_ram_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .LVL_WIDTH  (LVL_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr      (wr_en),
    .wr_data (data_i),
    .rd      (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level_o)
  );

  assign ready_o = !full;
  assign rd_en   = (state_q == EMIT);
  assign wr_en   = data_val_i && (!full || rd_en);
  assign drop    = data_val_i && full && !rd_en;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_en) state_d = EMIT;
      end
      EMIT: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // A sample arriving on the last slot cycle is emitted without a gap.
        if (cnt_q <= CNT_ONE) state_d = (!empty || wr_en) ? EMIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_val_o <= rd_en;
      if (rd_en) data_o <= head;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)           ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
    end
  end

endmodule
